fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the pipelined CPU. It sits directly upstream of the decode stage. It owns the program counter, drives iaddr to the combinational imem and samples idata the same cycle. It registers the fetched instruction into the IF/ID pipeline register, and handles stall, redirect (taken branch/jump from EX), halt-on-EBREAK and a fetched-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID
HALT_INSTR, 32'h0010_0073, EBREAK encoding that halts fetch

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
iaddr  out  32  fetch address to imem; equals pc register
idata  in  32  instruction word from imem, valid same cycle as iaddr
stall  in  1  hazard unit: hold PC and IF/ID contents
redirect_valid  in  1  EX resolved taken branch/jump this cycle
redirect_pc  in  32  target address for redirect
if_id_instr  out  32  registered instruction to decode
if_id_pc  out  32  registered PC of if_id_instr
if_id_pc4  out  32  registered if_id_pc + 4
if_id_valid  out  1  1 = real instruction, 0 = bubble
halted  out  1  fetch frozen on EBREAK
misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0
fetch_count  out  32  number of instructions written into IF/ID with valid=1

Behaviour:
- Reset (reset==0, async, immediate): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0, halted=0, misalign_err=0, fetch_count=0, FSM=BOOT.
- iaddr = pc at all times (combinational from the register). pc[1:0] is always 00.
- Latency: the word at iaddr=p appears on if_id_* at the next rising edge, so it is visible to decode one cycle later.
- FSM states:
  - BOOT: the first edge after reset release. IF/ID loads bubble, pc unchanged. Next state RUN. This gives the imem one full cycle at RESET_PC.
  - RUN: normal fetch.
  - HALT: pc frozen, IF/ID loads bubble each cycle, halted=1.
- Per-edge priority in RUN and HALT, highest first:
  1. redirect_valid=1:
     - pc <= {redirect_pc[31:2],2'b00}.
     - IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc/pc4 unchanged).
     - FSM <= RUN, so a halt is cancelled by an older branch.
     - misalign_err=1 for one cycle if redirect_pc[1:0]!=0.
     - Overrides stall.
  2. stall=1 (no redirect): pc, IF/ID, FSM and fetch_count all hold.
  3. RUN, idata==HALT_INSTR: IF/ID loads the EBREAK with valid=1 and fetch_count increments. pc holds and FSM <= HALT. halted asserts the following cycle.
  4. RUN, otherwise:
     - IF/ID <= {idata, pc, pc+4}, valid=1.
     - pc <= pc+4.
     - fetch_count += 1.
  5. HALT, no redirect: bubble, pc holds.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0 with no flag. fetch_count wraps modulo 2^32.
- misalign_err is registered and deasserts on the following edge unless another misaligned redirect occurs.
- stall in BOOT is ignored; BOOT always lasts exactly one cycle.
- Reset asserted mid-operation overrides everything and returns all state to reset values asynchronously.
- No X propagation: if_id_instr is never driven from idata while valid=0.

Test Plan:
- Reset/boot: hold reset=0 for 100 ns, release, imem[0..2]=addi. Expect iaddr=0 for two cycles (BOOT+first RUN). Then if_id_pc=0,4,8 with valid=1 on consecutive cycles and fetch_count=3.
- Stall: assert stall for 3 cycles while iaddr=8. Expect iaddr stays 8 and if_id_pc stays 4 with instr unchanged. After release, if_id_pc=8 next edge and fetch_count does not increment during the stall.
- Redirect beats stall: stall=1 and redirect_valid=1, redirect_pc=0x40 on the same edge. Expect iaddr=0x40 and if_id_valid=0, instr=0x00000013. Next edge if_id_pc=0x40, valid=1.
- Misaligned redirect: redirect_pc=0x42. Expect iaddr=0x40 and misalign_err=1 for exactly one cycle.
- Halt: imem[0x10]=0x00100073. Expect if_id_instr=0x00100073 valid=1 once, then halted=1, iaddr stuck at 0x10, valid=0 for 40 cycles, fetch_count frozen. Then redirect to 0x0 clears halted and fetch resumes at 0.
- Async reset mid-run: drop reset between edges at iaddr=0x24. Expect iaddr=0, if_id_valid=0 and fetch_count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the pipelined CPU. Owns the program counter,
// presents it to a combinational instruction memory, and registers the
// returned word into the IF/ID pipeline register. Handles hazard stalls,
// redirects from EX (taken branch/jump), halting on EBREAK, and counts the
// real instructions handed to decode.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   iaddr          out  fetch address to imem (the pc register)
//   idata          in   instruction word from imem, same cycle as iaddr
//   stall          in   hold pc and IF/ID contents
//   redirect_valid in   EX resolved a taken branch/jump this cycle
//   redirect_pc    in   redirect target
//   if_id_instr    out  registered instruction for decode
//   if_id_pc       out  registered pc of if_id_instr
//   if_id_pc4      out  registered if_id_pc + 4
//   if_id_valid    out  1 = real instruction, 0 = bubble
//   halted         out  fetch frozen on EBREAK
//   misalign_err   out  one-cycle pulse on a redirect with target[1:0] != 0
//   fetch_count    out  instructions written into IF/ID with valid=1
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] instr_q,   instr_d;
    logic [31:0] ifpc_q,    ifpc_d;
    logic [31:0] ifpc4_q,   ifpc4_d;
    logic        valid_q,   valid_d;
    logic        halted_q,  halted_d;
    logic        mis_q,     mis_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] pc_plus4_s;

    // Sequential pc + 4; wraps modulo 2^32 with no flag.
    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state logic: BOOT settle cycle, then redirect > stall > fetch/halt.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        count_d = count_q;
        mis_d   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Give imem one full cycle at RESET_PC; stall/redirect ignored.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (redirect_valid) begin
                    // Older branch wins over stall and cancels a pending halt.
                    pc_d    = {redirect_pc[31:2], 2'b00};
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = ST_RUN;
                    mis_d   = (redirect_pc[1:0] != 2'b00);
                end else if (stall) begin
                    state_d = state_q;
                end else if (state_q == ST_RUN) begin
                    instr_d = idata;
                    ifpc_d  = pc_q;
                    ifpc4_d = pc_plus4_s;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                    if (idata == HALT_INSTR) begin
                        // EBREAK goes to decode; pc parks on it.
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus4_s;
                    end
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: recover through the boot cycle.
                state_d = ST_BOOT;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            ifpc_q   <= 32'd0;
            ifpc4_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            ifpc4_q  <= ifpc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
            count_q  <= count_d;
        end
    end

    assign iaddr        = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = ifpc_q;
    assign if_id_pc4    = ifpc4_q;
    assign if_id_valid  = valid_q;
    assign halted       = halted_q;
    assign misalign_err = mis_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:63];

    fetch_stage dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational imem model: addresses past the table read as NOP.
    always_comb begin
        if (iaddr < 32'd256) idata = mem[iaddr[7:2]];
        else                 idata = NOP;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {i[11:0], 20'h00093};
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        // Reset state
        #50;
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_mis", 32'(misalign_err), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        #50;
        reset = 1'b1;

        // BOOT edge: bubble, pc stays
        tick();
        chk("boot_iaddr", iaddr, 32'd0);
        chk("boot_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("f0_pc", if_id_pc, 32'd0);
        chk("f0_pc4", if_id_pc4, 32'd4);
        chk("f0_instr", if_id_instr, 32'h0000_0093);
        chk("f0_valid", 32'(if_id_valid), 32'd1);
        chk("f0_iaddr", iaddr, 32'd4);
        tick();
        chk("f1_pc", if_id_pc, 32'd4);
        chk("f1_iaddr", iaddr, 32'd8);
        chk("f1_count", fetch_count, 32'd2);

        // Stall for 3 cycles at iaddr=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_iaddr", iaddr, 32'd8);
            chk("stall_pc", if_id_pc, 32'd4);
            chk("stall_instr", if_id_instr, 32'h0010_0093);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", if_id_pc, 32'd8);
        chk("unstall_count", fetch_count, 32'd3);
        chk("unstall_iaddr", iaddr, 32'h0C);

        // Redirect beats stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("redir_iaddr", iaddr, 32'h40);
        chk("redir_valid", 32'(if_id_valid), 32'd0);
        chk("redir_instr", if_id_instr, NOP);
        chk("redir_mis", 32'(misalign_err), 32'd0);
        chk("redir_count", fetch_count, 32'd3);
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        chk("redir_f_pc", if_id_pc, 32'h40);
        chk("redir_f_valid", 32'(if_id_valid), 32'd1);
        chk("redir_f_instr", if_id_instr, 32'h0100_0093);
        chk("redir_f_count", fetch_count, 32'd4);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        chk("mis_iaddr", iaddr, 32'h40);
        chk("mis_err", 32'(misalign_err), 32'd1);
        redirect_valid = 1'b0;
        tick();
        chk("mis_clear", 32'(misalign_err), 32'd0);
        chk("mis_f_pc", if_id_pc, 32'h40);
        chk("mis_f_count", fetch_count, 32'd5);

        // Halt on EBREAK at 0x10
        mem[4] = EBRK;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        chk("h_redir_iaddr", iaddr, 32'h10);
        redirect_valid = 1'b0;
        tick();
        chk("h_instr", if_id_instr, EBRK);
        chk("h_valid", 32'(if_id_valid), 32'd1);
        chk("h_pc", if_id_pc, 32'h10);
        chk("h_count", fetch_count, 32'd6);
        chk("h_iaddr", iaddr, 32'h10);
        chk("h_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("hold_halted", 32'(halted), 32'd1);
            chk("hold_iaddr", iaddr, 32'h10);
            chk("hold_valid", 32'(if_id_valid), 32'd0);
            chk("hold_count", fetch_count, 32'd6);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_iaddr", iaddr, 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("resume_pc", if_id_pc, 32'd0);
        chk("resume_valid", 32'(if_id_valid), 32'd1);
        chk("resume_count", fetch_count, 32'd7);
        mem[4] = 32'h0040_0093;

        // pc wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc4, 32'd0);
        chk("wrap_iaddr", iaddr, 32'd0);
        chk("wrap_count", fetch_count, 32'd8);

        // Run to 0x24, then async reset between edges
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("pre_rst_iaddr", iaddr, 32'h24);
        chk("pre_rst_count", fetch_count, 32'd9);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_iaddr", iaddr, 32'd0);
        chk("arst_valid", 32'(if_id_valid), 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("reboot_valid", 32'(if_id_valid), 32'd0);
        chk("reboot_iaddr", iaddr, 32'd0);
        tick();
        chk("reboot_f_pc", if_id_pc, 32'd0);
        chk("reboot_f_count", fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
